// File: rtl/tsv_pkg.sv
// Shared types and constants for the inter-layer (TSV) bus arbiters.
package tsv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap
  } state_e;

  // Discovery-frame token emitted by the self-test/chip-ID engine.
  localparam logic [15:0] TOKEN_BEEF = 16'hBEEF;

  // Requester that owns the bus exclusively until self-test completes.
  localparam int unsigned SELFTEST_REQ_IDX = 0;

endpackage

// File: rtl/tsv_bus_arbiter_if.sv
// Requester/arbiter signal bundle for the shared TSV bus.
interface tsv_bus_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 32
);

  logic                  sort_finish;
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      valid;
  logic [N_REQ-1:0]      last;
  logic [N_REQ*DW-1:0]   wdata;
  logic [N_REQ-1:0]      grant;
  logic [DW-1:0]         bus_data;
  logic                  bus_valid;
  logic                  busy;
  logic                  timeout_pulse;

  // Requester side.
  modport master (
    output sort_finish, req, valid, last, wdata,
    input  grant, bus_data, bus_valid, busy, timeout_pulse
  );

  // Arbiter side.
  modport slave (
    input  sort_finish, req, valid, last, wdata,
    output grant, bus_data, bus_valid, busy, timeout_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    logic [IW-1:0] pos;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/tsv_bus_arbiter.sv
// Shared TSV bus arbiter: self-test lockout, round-robin ownership, burst cap,
// inactivity timeout and a fixed idle gap between owners.
module tsv_bus_arbiter
  import tsv_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 20,
  parameter int unsigned GAP_CYC   = 2
) (
  input logic              clk,
  input logic              rst_n,
  tsv_bus_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = 5;
  localparam int unsigned GW = 3;
  localparam logic [N_REQ-1:0] SelftestMask = N_REQ'(1) << SELFTEST_REQ_IDX;

  state_e           state_q;
  logic [IW-1:0]    own_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [CW-1:0]    beat_cnt_q;
  logic [CW-1:0]    idle_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [DW-1:0]    bus_data_q;
  logic             bus_valid_q;
  logic             busy_q;
  logic             timeout_pulse_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;

  logic [DW-1:0]    words [N_REQ];
  logic             own_req, own_valid, own_last;
  logic [DW-1:0]    own_word;
  logic             rel_last, rel_burst, rel_drop, rel_tmo, rel_any;
  logic [IW-1:0]    next_ptr;

  // Before self-test completes only the self-test engine may compete.
  assign elig = bus.sort_finish ? bus.req : (bus.req & SelftestMask);

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (elig),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign words[gi] = bus.wdata[gi*DW +: DW];
  end

  assign own_req   = bus.req[own_q];
  assign own_valid = bus.valid[own_q];
  assign own_last  = bus.last[own_q];
  assign own_word  = words[own_q];

  // Release causes for the current owner; any one of them ends the grant.
  always_comb begin
    rel_last  = own_valid & own_last;
    rel_burst = own_valid & (beat_cnt_q == CW'(MAX_BURST - 1));
    rel_drop  = ~own_req;
    rel_tmo   = own_req & ~own_valid & (idle_cnt_q == CW'(TIMEOUT - 1));
    rel_any   = rel_last | rel_burst | rel_drop | rel_tmo;
  end

  assign next_ptr = (own_q == IW'(N_REQ - 1)) ? '0 : own_q + 1'b1;

  // Ownership FSM with registered grant, bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      own_q           <= '0;
      rr_ptr_q        <= '0;
      beat_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      gap_cnt_q       <= '0;
      grant_q         <= '0;
      bus_data_q      <= '0;
      bus_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          bus_valid_q <= 1'b0;
          if (pick_found) begin
            grant_q    <= pick_onehot;
            own_q      <= pick_idx;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (!own_req) begin
            // Owner withdrew: the beat on its lines this cycle is dropped.
            bus_valid_q <= 1'b0;
          end else begin
            bus_valid_q <= own_valid;
            if (own_valid) begin
              bus_data_q <= own_word;
              beat_cnt_q <= (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + 1'b1;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
            end
          end
          if (rel_any) begin
            grant_q         <= '0;
            rr_ptr_q        <= next_ptr;
            gap_cnt_q       <= '0;
            timeout_pulse_q <= rel_tmo;
            state_q         <= StGap;
          end
        end
        StGap: begin
          bus_valid_q <= 1'b0;
          if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.bus_data      = bus_data_q;
  assign bus.bus_valid     = bus_valid_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_tsv_bus_arbiter.sv
// Randomized bench for tsv_bus_arbiter against a transaction-level ownership model.
module tb_tsv_bus_arbiter;
  import tsv_pkg::*;

  localparam int N_REQ     = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;
  localparam int TIMEOUT   = 20;
  localparam int GAP_CYC   = 2;
  localparam int OW        = N_REQ + 3 + DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tsv_bus_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  tsv_bus_arbiter #(
    .N_REQ     (N_REQ),
    .DW        (DW),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: current owner (-1 = none), next-search start, beats/quiet cycles in
  // this grant, and idle gap cycles still to serve.
  int               m_owner, m_ptr, m_beats, m_quiet, m_gap;
  logic [N_REQ-1:0] m_grant;
  logic [DW-1:0]    m_data;
  logic             m_valid, m_busy, m_tmo;

  // Requester behaviour: beats still to send, last-every-N (0 = never), beats in
  // current burst, request held even with nothing to send, valid probability.
  int               remaining [N_REQ];
  int               blen      [N_REQ];
  int               bcnt      [N_REQ];
  logic [N_REQ-1:0] hold_req;
  int               vprob;

  function automatic logic [OW-1:0] observed();
    return {bus.grant, bus.bus_valid, bus.busy, bus.timeout_pulse, bus.bus_data};
  endfunction

  function automatic logic [OW-1:0] expected();
    return {m_grant, m_valid, m_busy, m_tmo, m_data};
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    int r = -1;
    for (int b = 0; b < N_REQ; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_quiet = 0; m_gap = 0;
    m_grant = '0; m_data = '0; m_valid = 1'b0; m_busy = 1'b0; m_tmo = 1'b0;
  endtask

  // One clock edge of ownership rules applied to the inputs seen at that edge.
  task automatic model_step();
    int  w;
    bit  rel;
    m_tmo = 1'b0;
    rel   = 1'b0;
    w     = m_owner;
    if (m_owner >= 0) begin
      if (!bus.req[w]) begin
        m_valid = 1'b0; rel = 1'b1;
      end else if (bus.valid[w]) begin
        m_valid = 1'b1;
        m_data  = bus.wdata[w*DW +: DW];
        m_beats++;
        m_quiet = 0;
        if (bus.last[w] || m_beats == MAX_BURST) rel = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_quiet++;
        if (m_quiet == TIMEOUT) begin m_tmo = 1'b1; rel = 1'b1; end
      end
      if (rel) begin
        m_owner = -1; m_ptr = (w + 1) % N_REQ; m_gap = GAP_CYC;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (m_ptr + k) % N_REQ;
        if (m_owner < 0 && bus.req[j] && (bus.sort_finish || j == int'(SELFTEST_REQ_IDX))) begin
          m_owner = j; m_beats = 0; m_quiet = 0;
        end
      end
    end
    m_grant = '0;
    if (m_owner >= 0) m_grant[m_owner] = 1'b1;
    m_busy = (m_owner >= 0) || (m_gap > 0);
  endtask

  // Requesters react to the grant they should hold in the coming cycle.
  task automatic drive();
    logic go;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req[i] = (remaining[i] > 0) || hold_req[i];
      go = m_grant[i] && (remaining[i] > 0) && (int'($urandom_range(99)) < vprob);
      if (go) begin
        remaining[i]--;
        bcnt[i]++;
        bus.valid[i] = 1'b1;
        bus.last[i]  = (blen[i] != 0) && (bcnt[i] == blen[i]);
        if (bus.last[i]) bcnt[i] = 0;
        if (i == int'(SELFTEST_REQ_IDX) && !bus.sort_finish)
          bus.wdata[i*DW +: DW] = {TOKEN_BEEF, 16'($urandom)};
        else
          bus.wdata[i*DW +: DW] = $urandom;
      end else begin
        bus.valid[i] = m_grant[i] ? 1'b0 : 1'($urandom_range(1));
        bus.last[i]  = 1'($urandom_range(1));
        bus.wdata[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input logic sf);
    rst_n           = 1'b0;
    bus.sort_finish = sf;
    bus.req         = '0;
    bus.valid       = '0;
    bus.last        = '0;
    bus.wdata       = '0;
    for (int i = 0; i < N_REQ; i++) begin remaining[i] = 0; blen[i] = 0; bcnt[i] = 0; end
    hold_req = '0;
    vprob    = 100;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    total++;
    if (observed() !== '0) begin
      bad++; $display("FAIL reset_values got=%h want=0", observed());
    end
    drive();
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, observed(), expected());
      end
      drive();
    end
  endtask

  task automatic test_selftest_lock();
    apply_reset(1'b0);
    hold_req = 4'b1110;
    drive();
    for (int c = 0; c < 50; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL lock c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c < 30) begin
        total++;
        if (bus.grant !== '0) begin
          bad++; $display("FAIL lock_no_grant c=%0d got=%b want=0000", c, bus.grant);
        end
      end
      if (c == 30) begin
        total++;
        if (bus.grant !== 4'b0001) begin
          bad++; $display("FAIL lock_grant0 got=%b want=0001", bus.grant);
        end
      end
      if (c == 29) begin remaining[0] = 3; blen[0] = 3; end
      drive();
    end
  endtask

  task automatic test_round_robin();
    int               order[$];
    int               gaps[$];
    int               exp_order[5] = '{0, 1, 2, 3, 0};
    int               zero_run = 0;
    logic [N_REQ-1:0] prev = '0;
    apply_reset(1'b1);
    for (int i = 0; i < N_REQ; i++) begin remaining[i] = 60; blen[i] = 3; end
    vprob = 75;
    drive();
    for (int c = 0; c < 150 && order.size() < 5; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL rr c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (bus.grant != '0 && prev == '0) begin
        order.push_back(onehot_idx(bus.grant));
        if (order.size() > 1) gaps.push_back(zero_run);
      end
      zero_run = (bus.grant == '0) ? zero_run + 1 : 0;
      prev = bus.grant;
      drive();
    end
    total++;
    if (order.size() != 5) begin
      bad++; $display("FAIL rr_grant_count got=%0d want=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (order[k] != exp_order[k]) begin
          bad++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, order[k], exp_order[k]);
        end
      end
      for (int k = 0; k < gaps.size(); k++) begin
        total++;
        if (gaps[k] != GAP_CYC + 1) begin
          bad++; $display("FAIL rr_gap k=%0d got=%0d want=%0d", k, gaps[k], GAP_CYC + 1);
        end
      end
    end
  endtask

  task automatic test_forced_release();
    int               rises = 0, first_beats = 0, second_beats = 0;
    logic [N_REQ-1:0] prev = '0;
    apply_reset(1'b1);
    remaining[2] = 12;
    drive();
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL burst c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (bus.grant != '0 && prev == '0) rises++;
      if (bus.bus_valid) begin
        if (rises <= 1) first_beats++;
        else second_beats++;
      end
      prev = bus.grant;
      drive();
    end
    total += 3;
    if (rises != 2) begin
      bad++; $display("FAIL burst_grants got=%0d want=2", rises);
    end
    if (first_beats != MAX_BURST) begin
      bad++; $display("FAIL burst_first got=%0d want=%0d", first_beats, MAX_BURST);
    end
    if (second_beats != 12 - MAX_BURST) begin
      bad++; $display("FAIL burst_second got=%0d want=%0d", second_beats, 12 - MAX_BURST);
    end
  endtask

  task automatic test_timeout();
    int g1 = -1, tp = -1, g2 = -1, pulses = 0;
    apply_reset(1'b1);
    hold_req[1]  = 1'b1;
    remaining[2] = 3;
    blen[2]      = 3;
    drive();
    for (int c = 0; c < 60; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL tmo c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (g1 < 0 && bus.grant === 4'b0010) g1 = c;
      if (g2 < 0 && bus.grant === 4'b0100) g2 = c;
      if (bus.timeout_pulse === 1'b1) begin
        pulses++;
        if (tp < 0) tp = c;
        hold_req[1] = 1'b0;
      end
      drive();
    end
    total += 3;
    if (pulses != 1) begin
      bad++; $display("FAIL tmo_pulses got=%0d want=1", pulses);
    end
    if (g1 < 0 || tp < 0 || tp - g1 != TIMEOUT) begin
      bad++; $display("FAIL tmo_latency got=%0d want=%0d", tp - g1, TIMEOUT);
    end
    if (tp < 0 || g2 < 0 || g2 - tp != GAP_CYC + 1) begin
      bad++; $display("FAIL tmo_regrant got=%0d want=%0d", g2 - tp, GAP_CYC + 1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    apply_reset(1'b1);
    remaining[3] = 20;
    drive();
    for (int c = 0; c < 20 && beats < 4; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL midrst c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (bus.bus_valid) beats++;
      if (beats < 4) drive();
    end
    total++;
    if (beats != 4) begin
      bad++; $display("FAIL midrst_beats got=%0d want=4", beats);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (observed() !== '0) begin
      bad++; $display("FAIL midrst_async got=%h want=0", observed());
    end
    model_reset();
    for (int i = 0; i < N_REQ; i++) begin remaining[i] = 0; bcnt[i] = 0; end
    hold_req = 4'b1010;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL postrst c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c == 0) begin
        total++;
        if (bus.grant !== 4'b0010) begin
          bad++; $display("FAIL postrst_grant got=%b want=0010", bus.grant);
        end
      end
      drive();
    end
  endtask

  task automatic test_sort_finish_rise();
    int               order[$];
    int               beats0 = 0;
    logic [N_REQ-1:0] prev = '0;
    apply_reset(1'b0);
    remaining[0] = 6; blen[0] = 6;
    remaining[3] = 3; blen[3] = 3;
    drive();
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("FAIL sfrise c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (bus.grant != '0 && prev == '0) order.push_back(onehot_idx(bus.grant));
      if (bus.bus_valid && order.size() == 1) beats0++;
      if (beats0 == 2) bus.sort_finish = 1'b1;
      prev = bus.grant;
      drive();
    end
    total += 2;
    if (beats0 != 6) begin
      bad++; $display("FAIL sfrise_beats0 got=%0d want=6", beats0);
    end
    if (order.size() != 2 || order[0] != 0 || order[1] != 3) begin
      bad++; $display("FAIL sfrise_order got=%p want=0,3", order);
    end
  endtask

  initial begin
    test_reset();
    test_selftest_lock();
    test_round_robin();
    test_forced_release();
    test_timeout();
    test_reset_mid_burst();
    test_sort_finish_rise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
